entry_mean_sequencer: RTL and testbench
=======================================

# entry_mean_sequencer

Sequencing controller that produces the five per-entry means (entry sum / 5) from one shared serial constant divider instead of five parallel combinational dividers. It captures a frame of five 16-bit entry sums and time-multiplexes a single restoring-division datapath across the entries. It then presents five 12-bit means together with a one-cycle `ready` strobe. It sits in the convolution/CFA pipeline between the per-entry accumulators and the downstream consumer of the means.

## Interface
- `IN_W`, 16, width of each entry sum
- `OUT_W`, 12, width of each mean
- `DIVISOR`, 5, constant divisor; ≥2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous assert, active-low (`rst`=0 resets)
- `start`  in  1  frame request; sampled only while `busy`=0
- `e1`..`e5`  in  IN_W each  entry sums, captured on accepted `start`
- `busy`  out  1  frame in progress; `start` ignored while high
- `mean_e1`..`mean_e5`  out  OUT_W each  registered means, held until next frame completes
- `ready`  out  1  one-cycle pulse: all five means updated
- `sat`  out  5  per-entry saturation flags; present only with `ENTRY_MEAN_SAT_EN`

## Operation
- FSM states: IDLE, DIV, STORE, DONE.
- IDLE: `busy`=0. On `start`=1:
  - capture `e1`..`e5` into internal regs;
  - load entry 0 into the divider;
  - set idx=0 and step=0;
  - go to DIV.
- DIV: one restoring step per cycle (shift remainder, trial subtract DIVISOR, set quotient bit). After step IN_W-1, go to STORE.
- STORE:
  - write the quotient of entry idx to `mean_e{idx+1}` (width rule below);
  - if idx=4, go to DONE;
  - otherwise idx++, load the next entry, step=0, go to DIV.
- DONE: `ready`=1 for this cycle only, then go to IDLE.
- `busy`=1 in DIV, STORE and DONE.
- Width rules:
  - remainder register is clog2(DIVISOR)+1 bits;
  - quotient register is IN_W bits;
  - quotient is truncated toward zero (floor) and the remainder is discarded.
- A quotient exceeding OUT_W bits is handled per Configuration.
- Entry registers are private. Changes on `e1`..`e5` after capture do not affect the frame in progress.
- Reset values:
  - state=IDLE, `busy`=0, `ready`=0;
  - all `mean_e*`=0, `sat`=0;
  - idx, step and working registers =0.
- Reset mid-frame: the frame is abandoned and no partial means are written. After `rst` rises, the block is in IDLE and the next `start` is processed normally.
- `start` held high continuously: a new frame is accepted on each entry to IDLE.

## Timing
- Accepting edge = edge with state=IDLE and `start`=1.
- Each entry takes IN_W DIV cycles plus 1 STORE cycle (17 cycles at defaults).
- Last STORE completes on the 85th edge after the accepting edge. `ready` is high in the following cycle and all `mean_e*` are valid in that cycle.
- IDLE is re-entered one cycle later. With `start` held, the accept-to-accept interval is 87 cycles.
- `mean_e{k}` changes at its own STORE edge, so earlier entries update before `ready`. The consumer samples only on `ready`.
- `ready` and `start` are never simultaneous in an accepting state. DONE does not accept.

## Configuration
- `ENTRY_MEAN_SAT_EN` defined:
  - quotient > 2^OUT_W−1 clamps to 2^OUT_W−1;
  - the corresponding `sat` bit is written 1, otherwise 0, at the same STORE edge.
- Not defined:
  - mean = low OUT_W bits of the quotient (wrap);
  - the `sat` port does not exist.

## Structure
- Package `entry_mean_pkg` holds:
  - state enum;
  - N_ENTRIES=5;
  - default IN_W, OUT_W, DIVISOR;
  - remainder-width function.
- Sub-module `serial_const_div`: holds the remainder and quotient registers.
  - Inputs: `load`, `dividend`, `step_en`.
  - Output: `quotient`.
  - The sequencer owns the FSM, idx, step counter and output registers.

## Test plan
- Frame 4095, 20475, 4520, 7568, 4832 → means 819, 4095, 904, 1513, 966; `ready` single pulse 86 cycles after accept; `busy` high for exactly those cycles.
- Frame 9685, 9606, 15986, 0, 2345 → 1937, 1921, 3197, 0, 469. Inputs are changed during DIV and the means are unaffected.
- `e1`=65535:
  - with `ENTRY_MEAN_SAT_EN`, `mean_e1`=4095 and `sat`=5'b00001;
  - without it, `mean_e1`=819.
- `start` pulsed while `busy`=1 → ignored. The second frame is accepted only after return to IDLE. First frame's means hold until the second frame's `ready`.
- `rst` low during DIV of entry 3 → all outputs 0 immediately. After release, a fresh frame gives correct means 86 cycles after its accept.
- `start` tied high for 3 frames → `ready` pulses every 87 cycles with correct means each time.

Source files
------------

// File: rtl/entry_mean_pkg.sv
// Shared types and defaults for the entry-mean sequencer and its serial constant divider.
package entry_mean_pkg;

    localparam int unsigned N_ENTRIES   = 5;
    localparam int unsigned IN_W_DEF    = 16;
    localparam int unsigned OUT_W_DEF   = 12;
    localparam int unsigned DIVISOR_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } state_t;

    // Remainder never exceeds divisor-1, plus one bit for the shifted trial value.
    function automatic int unsigned rem_width(input int unsigned divisor);
        return $clog2(divisor) + 1;
    endfunction

endpackage

// File: rtl/serial_const_div.sv
// One-bit-per-cycle restoring divider by a constant; quotient bits shift into the dividend register.
module serial_const_div
    import entry_mean_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned DIVISOR = DIVISOR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [IN_W-1:0] dividend,
    input  logic            step_en,
    output logic [IN_W-1:0] quotient
);

    localparam int unsigned REM_W = rem_width(DIVISOR);

    logic [REM_W-1:0] rem_q;
    logic [IN_W-1:0]  quo_q;
    logic [REM_W-1:0] trial_c;
    logic             fits_c;

    // Shift the next dividend MSB into the remainder and try the subtraction.
    always_comb begin
        trial_c = {rem_q[REM_W-2:0], quo_q[IN_W-1]};
        fits_c  = (trial_c >= REM_W'(DIVISOR));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
        end else if (step_en) begin
            rem_q <= fits_c ? (trial_c - REM_W'(DIVISOR)) : trial_c;
            quo_q <= {quo_q[IN_W-2:0], fits_c};
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/entry_mean_sequencer.sv
// Computes five entry means (sum / DIVISOR) by time-sharing one serial divider.
// Define ENTRY_MEAN_SAT_EN to clamp oversized quotients and expose the sat flags.
module entry_mean_sequencer
    import entry_mean_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned DIVISOR = DIVISOR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  e1,
    input  logic [IN_W-1:0]  e2,
    input  logic [IN_W-1:0]  e3,
    input  logic [IN_W-1:0]  e4,
    input  logic [IN_W-1:0]  e5,
    output logic             busy,
    output logic [OUT_W-1:0] mean_e1,
    output logic [OUT_W-1:0] mean_e2,
    output logic [OUT_W-1:0] mean_e3,
    output logic [OUT_W-1:0] mean_e4,
    output logic [OUT_W-1:0] mean_e5,
    output logic             ready
`ifdef ENTRY_MEAN_SAT_EN
    ,
    output logic [N_ENTRIES-1:0] sat
`endif
);

    localparam int unsigned IDX_W  = $clog2(N_ENTRIES);
    localparam int unsigned STEP_W = $clog2(IN_W);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ENTRIES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(IN_W - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [STEP_W-1:0]  step_q;
    logic [IN_W-1:0]    ent_q  [N_ENTRIES];
    logic [OUT_W-1:0]   mean_q [N_ENTRIES];

    logic [IDX_W-1:0]   idx_nxt_c;
    logic               div_load_c;
    logic               div_step_c;
    logic [IN_W-1:0]    div_dividend_c;
    logic [IN_W-1:0]    quotient_c;
    logic [OUT_W-1:0]   mean_nxt_c;

    serial_const_div #(
        .IN_W    (IN_W),
        .DIVISOR (DIVISOR)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load_c),
        .dividend (div_dividend_c),
        .step_en  (div_step_c),
        .quotient (quotient_c)
    );

    // Divider control: load e1 on accept, load the next captured entry on STORE.
    always_comb begin
        idx_nxt_c      = idx_q + IDX_W'(1);
        div_load_c     = 1'b0;
        div_step_c     = 1'b0;
        div_dividend_c = e1;
        case (state_q)
            ST_IDLE:  div_load_c = start;
            ST_DIV:   div_step_c = 1'b1;
            ST_STORE: begin
                if (idx_q != LAST_IDX) begin
                    div_load_c     = 1'b1;
                    div_dividend_c = ent_q[idx_nxt_c];
                end
            end
            default: ;
        endcase
    end

`ifdef ENTRY_MEAN_SAT_EN
    localparam logic [IN_W-1:0] MEAN_MAX = IN_W'((64'd1 << OUT_W) - 64'd1);

    logic over_c;

    always_comb begin
        over_c     = (quotient_c > MEAN_MAX);
        mean_nxt_c = over_c ? OUT_W'(MEAN_MAX) : OUT_W'(quotient_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat <= '0;
        end else if (state_q == ST_STORE) begin
            sat[idx_q] <= over_c;
        end
    end
`else
    always_comb mean_nxt_c = OUT_W'(quotient_c);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            step_q  <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                ent_q[i]  <= '0;
                mean_q[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ent_q[0] <= e1;
                        ent_q[1] <= e2;
                        ent_q[2] <= e3;
                        ent_q[3] <= e4;
                        ent_q[4] <= e5;
                        idx_q    <= '0;
                        step_q   <= '0;
                        busy     <= 1'b1;
                        state_q  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    mean_q[idx_q] <= mean_nxt_c;
                    if (idx_q == LAST_IDX) begin
                        ready   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_nxt_c;
                        step_q  <= '0;
                        state_q <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mean_e1 = mean_q[0];
    assign mean_e2 = mean_q[1];
    assign mean_e3 = mean_q[2];
    assign mean_e4 = mean_q[3];
    assign mean_e5 = mean_q[4];

endmodule

// File: tb/tb_entry_mean_sequencer.sv
// Scoreboard bench for entry_mean_sequencer; build with ENTRY_MEAN_SAT_EN to cover the clamping variant.
module tb_entry_mean_sequencer;

    typedef struct packed {
        logic [4:0][11:0] m;
        logic [4:0]       s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] e1, e2, e3, e4, e5;
    logic        busy;
    logic [11:0] mean_e1, mean_e2, mean_e3, mean_e4, mean_e5;
    logic        ready;
`ifdef ENTRY_MEAN_SAT_EN
    logic [4:0]  sat;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sbq[$];

    entry_mean_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .e1      (e1),
        .e2      (e2),
        .e3      (e3),
        .e4      (e4),
        .e5      (e5),
        .busy    (busy),
        .mean_e1 (mean_e1),
        .mean_e2 (mean_e2),
        .mean_e3 (mean_e3),
        .mean_e4 (mean_e4),
        .mean_e5 (mean_e5),
        .ready   (ready)
`ifdef ENTRY_MEAN_SAT_EN
        ,
        .sat     (sat)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer divide by 5, then clamp or wrap to 12 bits.
    function automatic exp_t model(input logic [4:0][15:0] v);
        exp_t r;
        int   q;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            q = 32'(v[i]) / 5;
`ifdef ENTRY_MEAN_SAT_EN
            if (q > 4095) begin
                r.m[i] = 12'd4095;
                r.s[i] = 1'b1;
            end else begin
                r.m[i] = 12'(q);
            end
`else
            r.m[i] = 12'(q);
`endif
        end
        return r;
    endfunction

    task automatic check_means(input string tag, input exp_t x);
        logic [4:0][11:0] got;
        got = {mean_e5, mean_e4, mean_e3, mean_e2, mean_e1};
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_mean_e%0d", tag, i + 1), 32'(got[i]), 32'(x.m[i]));
`ifdef ENTRY_MEAN_SAT_EN
        check({tag, "_sat"}, 32'(sat), 32'(x.s));
`endif
    endtask

    // Scoreboard: push on every accepting edge, pop and compare on ready.
    always @(posedge clk) begin
        if (rst && !busy && start)
            sbq.push_back(model({e5, e4, e3, e2, e1}));
        #1;
        if (ready) begin
            if (sbq.size() == 0) check("sb_pending", 32'(sbq.size()), 32'd1);
            else check_means("ready", sbq.pop_front());
        end
    end

    task automatic drive(input logic [4:0][15:0] v);
        e1 = v[0]; e2 = v[1]; e3 = v[2]; e4 = v[3]; e5 = v[4];
    endtask

    task automatic launch(input logic [4:0][15:0] v);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("idle_before_start", 32'(busy), 32'd0);
        drive(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_ready(input int poke_at, input logic [4:0][15:0] poke_v,
                              input logic poke_start, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_n++;
            if (lat == poke_at) begin
                drive(poke_v);
                start = poke_start;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            if (ready) break;
        end
        check("ready_seen", 32'(ready), 32'd1);
    endtask

    task automatic frame_timing(input string tag, input int lat, input int busy_n);
        check({tag, "_ready_edge"}, 32'(lat), 32'd85);
        check({tag, "_busy_cycles"}, 32'(busy_n + 1), 32'd86);
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check_means(tag, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][15:0] fa, fb, fs, fc, fd, fe, ff, junk;
        int lat, busy_n;
        int rc[3];

        fa   = {16'd4832, 16'd7568, 16'd4520, 16'd20475, 16'd4095};
        fb   = {16'd2345, 16'd0, 16'd15986, 16'd9606, 16'd9685};
        fs   = {16'd20474, 16'd4, 16'd5, 16'd20479, 16'd65535};
        fc   = {16'd11, 16'd222, 16'd3333, 16'd44444, 16'd55555};
        fd   = {16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd5000};
        fe   = {16'd65534, 16'd9, 16'd10, 16'd31415, 16'd27182};
        ff   = {16'd20000, 16'd15000, 16'd10000, 16'd5000, 16'd7};
        junk = {16'hFFFF, 16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF};

        rst   = 1'b0;
        start = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        launch(fa);
        wait_ready(-10, '0, 1'b0, lat, busy_n);
        frame_timing("fa", lat, busy_n);

        // Inputs scrambled mid-DIV must not disturb the captured frame.
        launch(fb);
        wait_ready(10, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
                   1'b0, lat, busy_n);
        frame_timing("fb", lat, busy_n);
        repeat (10) @(negedge clk);
        check_means("fb_hold", model(fb));

        launch(fs);
        wait_ready(-10, '0, 1'b0, lat, busy_n);
        frame_timing("fs", lat, busy_n);
`ifdef ENTRY_MEAN_SAT_EN
        check("fs_mean_e1_clamp", 32'(mean_e1), 32'd4095);
        check("fs_sat_bits", 32'(sat), 32'd1);
`else
        check("fs_mean_e1_wrap", 32'(mean_e1), 32'd819);
`endif

        // Start pulse while busy is ignored.
        launch(fc);
        wait_ready(20, junk, 1'b1, lat, busy_n);
        frame_timing("fc", lat, busy_n);
        check("fc_sb_empty", 32'(sbq.size()), 32'd0);

        // Reset during entry 3 division abandons the frame.
        launch(fd);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        launch(fe);
        wait_ready(-10, '0, 1'b0, lat, busy_n);
        frame_timing("fe", lat, busy_n);

        // Start held high: back-to-back frames.
        @(negedge clk);
        drive(ff);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rc[k] = 0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #1;
                if (ready) begin
                    rc[k] = cyc;
                    break;
                end
            end
            check("held_ready_seen", 32'(ready), 32'd1);
        end
        start = 1'b0;
        check("held_interval_1", 32'(rc[1] - rc[0]), 32'd87);
        check("held_interval_2", 32'(rc[2] - rc[1]), 32'd87);
        repeat (100) @(negedge clk);
        check("final_sb_empty", 32'(sbq.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
